// File: rtl/watch_mode_ctrl_pkg.sv
// Shared types and constants for the watch display-mode controller.
package watch_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_BLANK   = 2'd2
  } ctrl_state_t;

  localparam logic [3:0]  BLANK_HEX     = 4'hF;
  localparam int unsigned DEF_IN_CLK_HZ = 50_000_000;
  localparam int          IDLE_CNT_W    = 32;

  // Terminal count of the idle counter: hz*sec-1, clamped into 32 bits.
  function automatic logic [IDLE_CNT_W-1:0] idle_limit(input longint unsigned hz,
                                                       input longint unsigned sec);
    longint unsigned cycles;
    cycles = hz * sec;
    if (cycles == 0) return '0;
    if (cycles > 64'h0000_0000_FFFF_FFFF) return '1;
    return IDLE_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/watch_mode_ctrl_if.sv
// Bundle between the display modes (master side) and the mode controller (slave side).
interface watch_mode_ctrl_if #(
  parameter int N_MODES = 3
);
  localparam int MW = (N_MODES > 1) ? $clog2(N_MODES) : 1;

  logic                   key_long_1;
  logic                   key_long_2;
  logic                   key_first_1;
  logic                   key_first_2;
  logic                   key_double_long;
  logic [N_MODES-1:0]     next_mod_req;
  logic [N_MODES*16-1:0]  hex_in;

  logic [N_MODES-1:0]     mode_en;
  logic [N_MODES-1:0]     mode_ack;
  logic [N_MODES-1:0]     k_long_1;
  logic [N_MODES-1:0]     k_long_2;
  logic [N_MODES-1:0]     k_first_1;
  logic [N_MODES-1:0]     k_first_2;
  logic [N_MODES-1:0]     k_double_long;
  logic [3:0]             Hex_0;
  logic [3:0]             Hex_1;
  logic [3:0]             Hex_2;
  logic [3:0]             Hex_3;
  logic [MW-1:0]          active_mode;

  modport master (
    output key_long_1, key_long_2, key_first_1, key_first_2, key_double_long,
    output next_mod_req, hex_in,
    input  mode_en, mode_ack, k_long_1, k_long_2, k_first_1, k_first_2, k_double_long,
    input  Hex_0, Hex_1, Hex_2, Hex_3, active_mode
  );

  modport slave (
    input  key_long_1, key_long_2, key_first_1, key_first_2, key_double_long,
    input  next_mod_req, hex_in,
    output mode_en, mode_ack, k_long_1, k_long_2, k_first_1, k_first_2, k_double_long,
    output Hex_0, Hex_1, Hex_2, Hex_3, active_mode
  );

endinterface

// File: rtl/watch_mode_ctrl_idle_timer.sv
// Saturating inactivity counter with an expire flag at a fixed terminal count.
module idle_timer
  import watch_mode_ctrl_pkg::*;
#(
  parameter logic [IDLE_CNT_W-1:0] LIMIT = 32'd99
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  logic [IDLE_CNT_W-1:0] cnt;

  // Count idle cycles; clear has priority, and the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/watch_mode_ctrl.sv
// Arbitrates keys and the 4-digit display between N_MODES watch modes with a
// request/ack handoff, a blanking gap between owners and an idle return to mode 0.
module watch_mode_ctrl
  import watch_mode_ctrl_pkg::*;
#(
  parameter int          N_MODES      = 3,
  parameter int          BLANK_CYCLES = 4,
  parameter int unsigned IN_CLK_HZ    = DEF_IN_CLK_HZ,
  parameter int unsigned IDLE_SEC     = 30
) (
  input logic               clk,
  input logic               rst,
  watch_mode_ctrl_if.slave  bus
);

  localparam int MW = (N_MODES > 1) ? $clog2(N_MODES) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [IDLE_CNT_W-1:0] IDLE_LIMIT =
    idle_limit(64'(IN_CLK_HZ), 64'(IDLE_SEC));
  localparam logic [MW-1:0] LAST_MODE  = MW'(N_MODES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  ctrl_state_t        state, state_next;
  logic [MW-1:0]      mode_q, mode_next;
  logic [BW-1:0]      blank_q, blank_next;
  logic [N_MODES-1:0] ack_q, ack_next;
  logic [N_MODES-1:0] owner_onehot;
  logic [15:0]        owner_hex;
  logic               owner_req;
  logic               any_key;
  logic               idle_expired;
  logic               idle_clear;
  logic               timeout;

  assign owner_onehot = N_MODES'(1) << mode_q;
  assign owner_req    = bus.next_mod_req[mode_q];
  assign any_key      = bus.key_long_1 | bus.key_long_2 | bus.key_first_1 |
                        bus.key_first_2 | bus.key_double_long;

  // A key in the expiry cycle both restarts the counter and cancels the timeout.
  assign timeout    = (state == ST_ACTIVE) && (mode_q != '0) && idle_expired && !any_key;
  assign idle_clear = any_key || (state_next != state);

  idle_timer #(
    .LIMIT (IDLE_LIMIT)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (idle_clear),
    .expired (idle_expired)
  );

  // State register plus owner index, blank counter and registered acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ACTIVE;
      mode_q  <= '0;
      blank_q <= '0;
      ack_q   <= '0;
    end else begin
      state   <= state_next;
      mode_q  <= mode_next;
      blank_q <= blank_next;
      ack_q   <= ack_next;
    end
  end

  // Next-state logic: owner request beats idle timeout; release waits for the request to drop.
  always_comb begin
    state_next = state;
    mode_next  = mode_q;
    blank_next = blank_q;
    ack_next   = '0;
    case (state)
      ST_ACTIVE: begin
        if (owner_req) begin
          state_next = ST_RELEASE;
          ack_next   = owner_onehot;
        end else if (timeout) begin
          state_next = ST_BLANK;
          mode_next  = '0;
          blank_next = '0;
        end
      end
      ST_RELEASE: begin
        if (!owner_req) begin
          state_next = ST_BLANK;
          mode_next  = (mode_q == LAST_MODE) ? '0 : mode_q + 1'b1;
          blank_next = '0;
        end
      end
      ST_BLANK: begin
        if (blank_q == BLANK_LAST) begin
          state_next = ST_ACTIVE;
        end else begin
          blank_next = blank_q + 1'b1;
        end
      end
      default: begin
        state_next = ST_ACTIVE;
        mode_next  = '0;
        blank_next = '0;
      end
    endcase
  end

  // Output logic: owner gets enable, keys and the display only while ACTIVE; otherwise all blanked.
  always_comb begin
    owner_hex = {4{BLANK_HEX}};
    for (int i = 0; i < N_MODES; i++) begin
      if (mode_q == MW'(i)) owner_hex = bus.hex_in[16*i +: 16];
    end

    bus.mode_en       = '0;
    bus.k_long_1      = '0;
    bus.k_long_2      = '0;
    bus.k_first_1     = '0;
    bus.k_first_2     = '0;
    bus.k_double_long = '0;
    bus.Hex_0         = BLANK_HEX;
    bus.Hex_1         = BLANK_HEX;
    bus.Hex_2         = BLANK_HEX;
    bus.Hex_3         = BLANK_HEX;

    if (state == ST_ACTIVE) begin
      bus.mode_en       = owner_onehot;
      bus.k_long_1      = {N_MODES{bus.key_long_1}}      & owner_onehot;
      bus.k_long_2      = {N_MODES{bus.key_long_2}}      & owner_onehot;
      bus.k_first_1     = {N_MODES{bus.key_first_1}}     & owner_onehot;
      bus.k_first_2     = {N_MODES{bus.key_first_2}}     & owner_onehot;
      bus.k_double_long = {N_MODES{bus.key_double_long}} & owner_onehot;
      bus.Hex_0         = owner_hex[3:0];
      bus.Hex_1         = owner_hex[7:4];
      bus.Hex_2         = owner_hex[11:8];
      bus.Hex_3         = owner_hex[15:12];
    end
  end

  assign bus.mode_ack    = ack_q;
  assign bus.active_mode = mode_q;

endmodule

// File: doc/watch_mode_ctrl.md
WATCH_MODE_CTRL -- requirements
Module: watch_mode_ctrl

Interface
REQ-001 Parameter N_MODES, default 3, number of display modes sharing keys and digits (mode 0 = time of day).
REQ-002 Parameter BLANK_CYCLES, default 4, display-blank cycles inserted on each mode change (>=1).
REQ-003 Parameter IN_CLK_HZ, default 50_000_000, clock frequency.
REQ-004 Parameter IDLE_SEC, default 30, seconds without key activity before return to mode 0.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 key_long_1, key_long_2, key_first_1, key_first_2, key_double_long  in  1 each  one-cycle key event pulses from the debouncer.
REQ-008 next_mod_req  in  N_MODES  level request from mode i to hand the display to the next mode.
REQ-009 hex_in  in  N_MODES*16  mode i digits at bits [16i+15:16i], Hex_0 in the low nibble.
REQ-010 mode_en  out  N_MODES  one-hot enable of the owning mode; all zero outside ACTIVE.
REQ-011 mode_ack  out  N_MODES  one-cycle acknowledge of the accepted next_mod_req.
REQ-012 k_long_1, k_long_2, k_first_1, k_first_2, k_double_long  out  N_MODES each  key events routed to mode i only.
REQ-013 Hex_0, Hex_1, Hex_2, Hex_3  out  4 each  displayed digits.
REQ-014 active_mode  out  $clog2(N_MODES)  index of the current or pending owner.

Function
REQ-015 The FSM SHALL have states ACTIVE, RELEASE and BLANK.
REQ-016 In ACTIVE, mode_en SHALL be one-hot at active_mode, key events SHALL be forwarded combinationally to that mode only, and Hex_0..3 SHALL equal that mode's hex_in nibbles.
REQ-017 In ACTIVE, next_mod_req[active_mode]=1 SHALL produce mode_ack[active_mode]=1 for exactly the next cycle and a transition to RELEASE; requests from non-owning modes SHALL be ignored.
REQ-018 RELEASE SHALL hold until next_mod_req[active_mode]=0, then load active_mode with (active_mode+1) wrapping N_MODES-1 to 0, and enter BLANK.
REQ-019 BLANK SHALL last exactly BLANK_CYCLES cycles, then return to ACTIVE.
REQ-020 In RELEASE and BLANK, mode_en SHALL be zero, every routed key output SHALL be 0 (events dropped, not queued), and Hex_0..3 SHALL be 4'hF.
REQ-021 An idle counter SHALL clear on any key event input or any state change and increment otherwise; reaching IN_CLK_HZ*IDLE_SEC-1 in ACTIVE with active_mode!=0 SHALL load active_mode=0 and enter BLANK without mode_ack.
REQ-022 Owner next_mod_req and idle timeout in the same cycle: next_mod_req SHALL win.
REQ-023 A key event in the timeout cycle SHALL clear the counter and suppress the timeout.
REQ-024 The idle counter SHALL be 32 bits and saturate, never wrap; in mode 0 it SHALL not trigger.

Reset
REQ-025 On rst: state ACTIVE, active_mode=0, idle counter 0, mode_ack=0; mode_en=1 (one-hot bit 0) and display follows mode 0 from the first post-reset cycle.
REQ-026 rst asserted in RELEASE or BLANK SHALL abandon the handoff and apply REQ-025 on the next edge.

Structure
REQ-027 Shared package SHALL hold the FSM state enum, BLANK_HEX=4'hF, and the IN_CLK_HZ default.
REQ-028 Sub-module idle_timer (counter, clear, saturate, expire flag) SHALL be instantiated once; all else in watch_mode_ctrl.

Verification
REQ-029 Reset, N_MODES=3, hex_in mode0=16'h1234 -> Hex_0..3 = 4,3,2,1, mode_en=3'b001, key_first_1 pulse appears only on k_first_1[0].
REQ-030 Mode 0 raises next_mod_req for 3 cycles -> one mode_ack[0] pulse, Hex=F for 4 cycles after release, then mode_en=3'b010, active_mode=1.
REQ-031 From mode 2, handoff -> active_mode wraps to 0; next_mod_req[1]=1 while mode 0 owns -> no ack, no change.
REQ-032 key_long_2 during BLANK -> all k_long_2 outputs 0; not replayed after ACTIVE.
REQ-033 IDLE_SEC scaled to 100 cycles, mode 1 active, no keys -> BLANK at cycle 100, then mode 0; key at cycle 99 -> no timeout.
REQ-034 rst pulse in BLANK toward mode 1 -> next cycle ACTIVE, active_mode=0, Hex follows mode 0.
